// File: rtl/ram_6c_arbiter.sv
// Shares one sync-read RAM between CPU and video scan; zero-fills it after reset, then round-robins.
// Grant is same-cycle, ack/data one cycle later; a losing requester just keeps req high and retries.
module ram_6c_arbiter #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_din,
  output logic                    cpu_ack,
  output logic [data_width_g-1:0] cpu_dout,
  input  logic                    vid_req,
  input  logic [addr_width_g-1:0] vid_addr,
  output logic                    vid_ack,
  output logic [data_width_g-1:0] vid_dout,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q,
  output logic                    clearing
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [addr_width_g-1:0] clr_addr;
  logic                    cpu_pend;
  logic                    vid_pend;
  logic                    last_vid;
  logic                    cpu_elig;
  logic                    vid_elig;
  logic                    cpu_grant;
  logic                    vid_grant;

  // A requester in its own ack cycle is masked, so two sides interleave back to back.
  always_comb begin
    cpu_elig  = (state == RUN) && cpu_req && !cpu_pend;
    vid_elig  = (state == RUN) && vid_req && !vid_pend;
    cpu_grant = cpu_elig && (!vid_elig || last_vid);
    vid_grant = vid_elig && !cpu_grant;
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (state == CLEAR) begin
      ram_address = clr_addr;
      ram_wren    = 1'b1;
    end else if (cpu_grant) begin
      ram_address = cpu_addr;
      ram_data    = cpu_din;
      ram_wren    = cpu_we;
    end else if (vid_grant) begin
      ram_address = vid_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      cpu_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_pend <= 1'b0;
      vid_pend <= 1'b0;
      last_vid <= 1'b1;
    end else begin
      cpu_ack  <= cpu_grant;
      vid_ack  <= vid_grant;
      cpu_pend <= cpu_grant;
      vid_pend <= vid_grant;
      if (cpu_grant) begin
        last_vid <= 1'b0;
      end else if (vid_grant) begin
        last_vid <= 1'b1;
      end
      if (state == CLEAR) begin
        clr_addr <= clr_addr + addr_width_g'(1);
        if (&clr_addr) begin
          state <= RUN;
        end
      end
    end
  end

  assign cpu_dout = ram_q;
  assign vid_dout = ram_q;
  assign clearing = (state == CLEAR);

endmodule

// File: tb/tb_ram_6c_arbiter.sv
// Bench for ram_6c_arbiter: behavioural write-first RAM, shadow memory model and per-scenario tasks.
module tb_ram_6c_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_ack;
  logic [DW-1:0] cpu_dout;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_dout;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          clearing;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          last_vid_served;
  int            n_cmp = 0;
  int            n_bad = 0;

  ram_6c_arbiter #(.addr_width_g(AW), .data_width_g(DW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .clearing(clearing)
  );

  always #5 clock = ~clock;

  // Single-port RAM, registered read, write-first; starts full of garbage.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  always @(posedge clock) begin
    ram_q <= ram_wren ? ram_data : mem[ram_address];
    if (ram_wren) mem[ram_address] = ram_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] q, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; lat = -1; q = 'x;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      sample();
      if (cpu_ack === 1'b1) begin
        lat = i;
        q   = cpu_dout;
      end
      step();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    if (lat >= 0) begin
      last_vid_served = 1'b0;
      if (we) exp_mem[a] = d;
    end
  endtask

  task automatic vid_access(input logic [AW-1:0] a, output logic [DW-1:0] q, output int lat);
    vid_req = 1'b1; vid_addr = a; lat = -1; q = 'x;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      sample();
      if (vid_ack === 1'b1) begin
        lat = i;
        q   = vid_dout;
      end
      step();
    end
    vid_req = 1'b0;
    if (lat >= 0) last_vid_served = 1'b1;
  endtask

  // Runs while clearing is high; returns at the negedge of the first non-clearing cycle.
  task automatic watch_fill(output int n, output int bad, output int acks);
    logic done;
    n = 0; bad = 0; acks = 0; done = 1'b0;
    for (int i = 0; i < DEPTH + 16 && !done; i++) begin
      sample();
      if (clearing !== 1'b1) begin
        done = 1'b1;
      end else begin
        if (ram_wren !== 1'b1 || ram_address !== AW'(n) || ram_data !== '0) bad++;
        if (cpu_ack === 1'b1 || vid_ack === 1'b1) acks++;
        n++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    int n, bad, acks, lat, rd_bad, lat_bad;
    logic [DW-1:0] q;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0;
    step(); step();
    sample();
    n_cmp++; if (clearing !== 1'b1) begin n_bad++; $display("FAIL reset_clearing: got %b want 1", clearing); end
    n_cmp++; if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) begin n_bad++; $display("FAIL reset_acks: got cpu=%b vid=%b want 0 0", cpu_ack, vid_ack); end
    n_cmp++; if (ram_wren !== 1'b1 || ram_address !== '0) begin n_bad++; $display("FAIL reset_ram: got wren=%b addr=%h want 1 000", ram_wren, ram_address); end
    step();
    reset = 1'b0;
    watch_fill(n, bad, acks);
    n_cmp++; if (n !== DEPTH) begin n_bad++; $display("FAIL fill_length: got %0d want %0d", n, DEPTH); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL fill_writes: got %0d bad cycles want 0", bad); end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL fill_acks: got %0d acks want 0", acks); end
    step();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    last_vid_served = 1'b1;
    rd_bad = 0; lat_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_access(1'b0, AW'(i), '0, q, lat);
      if (q !== exp_mem[i]) rd_bad++;
      if (lat !== 1) lat_bad++;
    end
    n_cmp++; if (rd_bad !== 0) begin n_bad++; $display("FAIL readback_zero: got %0d nonzero words want 0", rd_bad); end
    n_cmp++; if (lat_bad !== 0) begin n_bad++; $display("FAIL readback_latency: got %0d slow reads want 0", lat_bad); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [DW-1:0] q;
    cpu_access(1'b1, 11'h123, 8'h5A, q, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
    n_cmp++; if (q !== 8'h5A) begin n_bad++; $display("FAIL wr_dout: got %h want 5a", q); end
    cpu_access(1'b0, 11'h123, 8'h00, q, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rd_latency: got %0d want 1", lat); end
    n_cmp++; if (q !== exp_mem[11'h123]) begin n_bad++; $display("FAIL rd_dout: got %h want %h", q, exp_mem[11'h123]); end
  endtask

  task automatic test_interleave();
    int lat;
    logic [DW-1:0] q;
    logic first_vid, g, g_prev;
    vid_access(11'h010, q, lat);
    n_cmp++; if (lat !== 1 || q !== exp_mem[11'h010]) begin n_bad++; $display("FAIL vid_single: got lat=%0d q=%h want 1 %h", lat, q, exp_mem[11'h010]); end
    first_vid = ~last_vid_served;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123; vid_req = 1'b1; vid_addr = 11'h010;
    g_prev = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) begin cpu_req = 1'b0; vid_req = 1'b0; end
      g = first_vid ^ (c % 2 == 1);
      sample();
      if (c < 8) begin
        n_cmp++;
        if (ram_address !== (g ? 11'h010 : 11'h123) || ram_wren !== 1'b0) begin
          n_bad++; $display("FAIL ilv_grant c=%0d: got addr=%h wren=%b want %h 0", c, ram_address, ram_wren, g ? 11'h010 : 11'h123);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if (cpu_ack !== ~g_prev || vid_ack !== g_prev) begin
          n_bad++; $display("FAIL ilv_ack c=%0d: got cpu=%b vid=%b want %b %b", c, cpu_ack, vid_ack, ~g_prev, g_prev);
        end
        n_cmp++;
        if (g_prev ? (vid_dout !== exp_mem[11'h010]) : (cpu_dout !== exp_mem[11'h123])) begin
          n_bad++; $display("FAIL ilv_data c=%0d: got cpu=%h vid=%h want cpu=%h vid=%h", c, cpu_dout, vid_dout, exp_mem[11'h123], exp_mem[11'h010]);
        end
      end
      g_prev = g;
      step();
    end
    last_vid_served = ~first_vid;
  endtask

  task automatic test_video_stream();
    int lat, k, ack_bad, data_bad, wren_seen;
    logic [DW-1:0] q;
    for (int i = 0; i < 16; i++) cpu_access(1'b1, AW'(11'h200 + i), DW'($urandom), q, lat);
    k = 0; ack_bad = 0; data_bad = 0; wren_seen = 0;
    vid_req = 1'b1;
    for (int c = 0; c < 80 && k < 16; c++) begin
      vid_addr = AW'(11'h200 + k);
      sample();
      if (ram_wren === 1'b1) wren_seen++;
      if (vid_ack === 1'b1) begin
        if (c !== 2 * k + 1) ack_bad++;
        if (vid_dout !== exp_mem[11'h200 + k]) data_bad++;
        k++;
      end
      step();
    end
    vid_req = 1'b0;
    last_vid_served = 1'b1;
    n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL vs_count: got %0d acks want 16", k); end
    n_cmp++; if (ack_bad !== 0) begin n_bad++; $display("FAIL vs_spacing: got %0d off-slot acks want 0", ack_bad); end
    n_cmp++; if (data_bad !== 0) begin n_bad++; $display("FAIL vs_data: got %0d wrong words want 0", data_bad); end
    n_cmp++; if (wren_seen !== 0) begin n_bad++; $display("FAIL vs_wren: got %0d write cycles want 0", wren_seen); end
  endtask

  task automatic test_random();
    logic cpu_on, vid_on, cw, cpu_fast, vid_fast;
    logic [AW-1:0] ca, va;
    logic [DW-1:0] cd;
    int cpu_start, vid_start, n_cpu, n_vid, lat_bad, data_bad, wren_bad, spur, lat;
    cpu_on = 1'b0; vid_on = 1'b0; cw = 1'b0; ca = '0; va = '0; cd = '0;
    cpu_fast = 1'b0; vid_fast = 1'b0; cpu_start = 0; vid_start = 0;
    n_cpu = 0; n_vid = 0; lat_bad = 0; data_bad = 0; wren_bad = 0; spur = 0;
    for (int c = 0; c < 620 && (c < 600 || cpu_on || vid_on); c++) begin
      if (c < 600 && !cpu_on && $urandom_range(1, 0) == 1) begin
        cpu_on = 1'b1; cpu_start = c; cw = 1'($urandom_range(1, 0)); cd = DW'($urandom);
        ca = cw ? AW'($urandom_range(DEPTH / 2 - 1, 0)) : AW'($urandom_range(DEPTH - 1, 0));
      end
      if (c < 600 && !vid_on && $urandom_range(1, 0) == 1) begin
        vid_on = 1'b1; vid_start = c; va = AW'($urandom_range(DEPTH - 1, DEPTH / 2));
      end
      if (cpu_on && cpu_start == c) cpu_fast = !vid_on;
      if (vid_on && vid_start == c) vid_fast = !cpu_on;
      cpu_req = cpu_on; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
      vid_req = vid_on; vid_addr = va;
      sample();
      if (ram_wren === 1'b1 && !(cpu_on && cw && cpu_ack !== 1'b1)) wren_bad++;
      if (cpu_ack === 1'b1) begin
        if (!cpu_on) spur++;
        else begin
          lat = c - cpu_start;
          if (lat < 1 || lat > 2 || (cpu_fast && lat != 1)) lat_bad++;
          if (cw) exp_mem[ca] = cd;
          if (cpu_dout !== exp_mem[ca]) data_bad++;
          cpu_on = 1'b0; n_cpu++;
        end
      end
      if (vid_ack === 1'b1) begin
        if (!vid_on) spur++;
        else begin
          lat = c - vid_start;
          if (lat < 1 || lat > 2 || (vid_fast && lat != 1)) lat_bad++;
          if (vid_dout !== exp_mem[va]) data_bad++;
          vid_on = 1'b0; n_vid++;
        end
      end
      if (cpu_on && c - cpu_start == 3) lat_bad++;
      if (vid_on && c - vid_start == 3) lat_bad++;
      step();
    end
    cpu_req = 1'b0; vid_req = 1'b0; cpu_we = 1'b0;
    step();
    n_cmp++; if (n_cpu < 50 || n_vid < 50) begin n_bad++; $display("FAIL rnd_activity: got cpu=%0d vid=%0d want >=50 each", n_cpu, n_vid); end
    n_cmp++; if (lat_bad !== 0) begin n_bad++; $display("FAIL rnd_latency: got %0d bad latencies want 0", lat_bad); end
    n_cmp++; if (data_bad !== 0) begin n_bad++; $display("FAIL rnd_data: got %0d wrong words want 0", data_bad); end
    n_cmp++; if (wren_bad !== 0) begin n_bad++; $display("FAIL rnd_wren: got %0d stray writes want 0", wren_bad); end
    n_cmp++; if (spur !== 0 || cpu_on || vid_on) begin n_bad++; $display("FAIL rnd_protocol: got spurious=%0d open=%b%b want 0 00", spur, cpu_on, vid_on); end
  endtask

  task automatic test_reset_mid_fill();
    int n, bad, acks, early_bad;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123; vid_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    early_bad = 0;
    for (int i = 0; i < 7; i++) begin
      sample();
      if (clearing !== 1'b1 || ram_address !== AW'(i) || cpu_ack === 1'b1) early_bad++;
      step();
    end
    reset = 1'b1;
    sample();
    n_cmp++; if (ram_address !== 11'h007 || early_bad !== 0) begin n_bad++; $display("FAIL mf_prefill: got addr=%h bad=%0d want 007 0", ram_address, early_bad); end
    step();
    reset = 1'b0;
    watch_fill(n, bad, acks);
    n_cmp++; if (n !== DEPTH || bad !== 0) begin n_bad++; $display("FAIL mf_refill: got len=%0d bad=%0d want %0d 0", n, bad, DEPTH); end
    n_cmp++; if (acks !== 0 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL mf_ack_early: got %0d acks want 0", acks + (cpu_ack === 1'b1)); end
    step();
    sample();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_dout !== exp_mem[11'h123]) begin n_bad++; $display("FAIL mf_served: got ack=%b dout=%h want 1 %h", cpu_ack, cpu_dout, exp_mem[11'h123]); end
    step();
    cpu_req = 1'b0;
    last_vid_served = 1'b0;
    step();
  endtask

  task automatic test_reset_in_grant();
    int n, bad, acks;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005; vid_req = 1'b0;
    reset = 1'b1;
    sample();
    n_cmp++; if (ram_address !== 11'h005 || ram_wren !== 1'b0) begin n_bad++; $display("FAIL rg_grant: got addr=%h wren=%b want 005 0", ram_address, ram_wren); end
    step();
    reset = 1'b0;
    watch_fill(n, bad, acks);
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rg_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (n !== DEPTH || bad !== 0) begin n_bad++; $display("FAIL rg_refill: got len=%0d bad=%0d want %0d 0", n, bad, DEPTH); end
    step();
    sample();
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_dout !== exp_mem[11'h005]) begin n_bad++; $display("FAIL rg_served: got ack=%b dout=%h want 1 %h", cpu_ack, cpu_dout, exp_mem[11'h005]); end
    step();
    cpu_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0; last_vid_served = 1'b1;
    test_reset();
    test_write_read();
    test_interleave();
    test_video_stream();
    test_random();
    test_reset_mid_fill();
    test_reset_in_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
